lsl_shift_sequencer: RTL and testbench

//  Multi-cycle logical-shift-left front end for the 8-bit shifter datapath.

---
 rtl/lsl_shift_sequencer_pkg.sv | 11 +
 rtl/lsl_shift_sequencer_if.sv | 24 ++
 rtl/lsl_shift_sequencer_step.sv | 10 +
 rtl/lsl_shift_sequencer.sv | 75 +++++++
 tb/tb_lsl_shift_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/lsl_shift_sequencer_pkg.sv
// Shared types and constants for the multi-cycle logical-shift-left sequencer.
package lsl_seq_pkg;
    localparam int STEP_MAX = 3;
    localparam int STEP_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;
endpackage

// File: rtl/lsl_shift_sequencer_if.sv
// Operand/result handshake bundle between a producer/consumer and the shift sequencer.
interface lsl_shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_in;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d_out;
    logic             busy;

    modport master (
        output in_valid, d_in, shamt, out_ready,
        input  in_ready, out_valid, d_out, busy
    );

    modport slave (
        input  in_valid, d_in, shamt, out_ready,
        output in_ready, out_valid, d_out, busy
    );
endinterface

// File: rtl/lsl_shift_sequencer_step.sv
// One iteration stage: WIDTH-bit left shift by 0..3 positions, zero fill.
module lsl_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_amt,
    output logic [WIDTH-1:0] o_data
);
    assign o_data = i_data << i_amt;
endmodule

// File: rtl/lsl_shift_sequencer.sv
// Multi-cycle logical-shift-left sequencer: consumes up to 3 positions per cycle.
// Optional LSL_SAT_FAST_EN: amounts >= WIDTH complete at accept with a zero result.
module lsl_shift_sequencer
    import lsl_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    lsl_shift_sequencer_if.slave bus
);
    state_t              r_state;
    logic [WIDTH-1:0]    r_data;
    logic [SHW-1:0]      r_rem;
    logic [STEP_W-1:0]   w_step;
    logic [WIDTH-1:0]    w_step_out;

    // Step never exceeds the remaining amount, so r_rem cannot underflow.
    always_comb begin
        w_step = r_rem[STEP_W-1:0];
        if (r_rem > SHW'(STEP_MAX))
            w_step = STEP_W'(STEP_MAX);
    end

    lsl_step #(.WIDTH(WIDTH)) u_step (
        .i_data (r_data),
        .i_amt  (w_step),
        .o_data (w_step_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
`ifdef LSL_SAT_FAST_EN
                        if (int'(bus.shamt) >= WIDTH) begin
                            r_data  <= '0;
                            r_rem   <= '0;
                            r_state <= DONE;
                        end else begin
`else
                        begin
`endif
                            r_data  <= bus.d_in;
                            r_rem   <= bus.shamt;
                            r_state <= (bus.shamt == '0) ? DONE : SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_data <= w_step_out;
                    r_rem  <= r_rem - SHW'(w_step);
                    if (r_rem <= SHW'(STEP_MAX))
                        r_state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.d_out     = r_data;
endmodule

// File: tb/tb_lsl_shift_sequencer.sv
// Directed self-checking bench for lsl_shift_sequencer (honours LSL_SAT_FAST_EN).
module tb_lsl_shift_sequencer;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    lsl_shift_sequencer_if #(.WIDTH(8), .SHW(4)) bus ();

    lsl_shift_sequencer #(.WIDTH(8), .SHW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand, measure edges from accept to out_valid, check result, hand off.
    task automatic run(input string tag, input logic [7:0] d, input logic [3:0] sh,
                       input int exp_lat, input logic [7:0] exp_res);
        int cnt;
        bus.in_valid  = 1'b1;
        bus.d_in      = d;
        bus.shamt     = sh;
        bus.out_ready = 1'b0;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.d_in     = 8'hEE;
        bus.shamt    = 4'hF;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
        check({tag, "_dout"}, 32'(bus.d_out), 32'(exp_res));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_ov_lo"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        n_checks      = 0;
        n_errors      = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.d_in      = '0;
        bus.shamt     = '0;
        bus.out_ready = 1'b0;
        #2;
        check("rst_dout", 32'(bus.d_out), 32'd0);
        check("rst_ov", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ir", 32'(bus.in_ready), 32'd1);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Edges after the accept edge: 0 for shamt 0, else ceil(shamt/3).
        run("b5_5", 8'hB5, 4'd5, 2, 8'hA0);
        run("3c_0", 8'h3C, 4'd0, 0, 8'h3C);
`ifdef LSL_SAT_FAST_EN
        run("ff_9", 8'hFF, 4'd9, 0, 8'h00);
`else
        run("ff_9", 8'hFF, 4'd9, 3, 8'h00);
`endif
        run("01_2", 8'h01, 4'd2, 1, 8'h04);

        // Result held under back-pressure; offers during DONE are ignored.
        bus.in_valid = 1'b1;
        bus.d_in     = 8'h81;
        bus.shamt    = 4'd7;
        tick();
        bus.d_in  = 8'h55;
        bus.shamt = 4'd2;
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check("hold_lat", 32'(cnt), 32'd3);
        for (int i = 0; i < 4; i++) begin
            check("hold_dout", 32'(bus.d_out), 32'h80);
            check("hold_ir", 32'(bus.in_ready), 32'd0);
            check("hold_ov", 32'(bus.out_valid), 32'd1);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("hold_handoff", 32'(bus.out_valid), 32'd0);
        check("hold_nocap", 32'(bus.d_out), 32'h80);
        check("hold_busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a long shift.
        bus.in_valid = 1'b1;
        bus.d_in     = 8'h01;
        bus.shamt    = 4'd15;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_data", 32'(bus.d_out), 32'h08);
        #2 reset_n = 1'b0;
        #1;
        check("arst_dout", 32'(bus.d_out), 32'd0);
        check("arst_ov", 32'(bus.out_valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_ir", 32'(bus.in_ready), 32'd1);
        #2 reset_n = 1'b1;
        tick();
        run("post_rst", 8'h01, 4'd1, 1, 8'h02);

        // Back-to-back with out_ready held high.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.d_in      = 8'h01;
        bus.shamt     = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("b2b1_ov", 32'(bus.out_valid), 32'd1);
        check("b2b1_dout", 32'(bus.d_out), 32'h08);
        bus.in_valid = 1'b1;
        bus.d_in     = 8'h01;
        bus.shamt    = 4'd6;
        tick();
        check("b2b_handoff_ir", 32'(bus.in_ready), 32'd1);
        check("b2b_handoff_ov", 32'(bus.out_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("b2b2_accept", 32'(bus.busy), 32'd1);
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check("b2b2_lat", 32'(cnt), 32'd2);
        check("b2b2_dout", 32'(bus.d_out), 32'h40);
        tick();
        check("b2b2_idle", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
